// File: rtl/sd_clk_gen_if.sv
// Control/strobe bundle between the register block, the SD clock divider and
// the cmd/data serialisers.
interface sd_clk_gen_if #(
  parameter int DIV_W = 8
);
  logic             enable;
  logic [DIV_W-1:0] divider;
  logic             stop_req;
  logic             sd_clk;
  logic             rise;
  logic             fall;
  logic             stopped;

  modport master (
    output enable, divider, stop_req,
    input  sd_clk, rise, fall, stopped
  );

  modport slave (
    input  enable, divider, stop_req,
    output sd_clk, rise, fall, stopped
  );
endinterface

// File: rtl/sd_clk_gen.sv
// SD card clock divider: registered sd_clk with edge-aligned rise/fall strobes,
// low-phase freeze on stop_req and glitch-free enable/disable.
module sd_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  sd_clk_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sd_clk_q, sd_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             stopped_q, stopped_d;
  logic             tc_s;

  assign tc_s = (cnt_q == div_q);

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {DIV_W{1'b0}};
      div_q     <= {DIV_W{1'b0}};
      sd_clk_q  <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      stopped_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sd_clk_q  <= sd_clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stopped_q <= stopped_d;
    end
  end

  // Next-state and next-output logic; the divider is only latched when a low phase begins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    sd_clk_d  = sd_clk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    stopped_d = stopped_q;
    case (state_q)
      ST_IDLE: begin
        sd_clk_d = 1'b0;
        if (bus.enable) begin
          state_d   = ST_LOW;
          cnt_d     = {DIV_W{1'b0}};
          div_d     = bus.divider;
          stopped_d = 1'b0;
        end else begin
          state_d   = ST_IDLE;
          stopped_d = 1'b1;
        end
      end
      ST_LOW: begin
        sd_clk_d = 1'b0;
        // Disable has priority over a pending stop so the clock always parks in IDLE.
        if (!bus.enable) begin
          state_d   = ST_IDLE;
          cnt_d     = {DIV_W{1'b0}};
          stopped_d = 1'b1;
        end else if (!tc_s) begin
          cnt_d     = cnt_q + DIV_W'(1);
          stopped_d = 1'b0;
        end else if (bus.stop_req) begin
          stopped_d = 1'b1;
        end else begin
          state_d   = ST_HIGH;
          sd_clk_d  = 1'b1;
          rise_d    = 1'b1;
          cnt_d     = {DIV_W{1'b0}};
          stopped_d = 1'b0;
        end
      end
      ST_HIGH: begin
        sd_clk_d  = 1'b1;
        stopped_d = 1'b0;
        if (!tc_s) begin
          cnt_d = cnt_q + DIV_W'(1);
        end else begin
          fall_d   = 1'b1;
          sd_clk_d = 1'b0;
          cnt_d    = {DIV_W{1'b0}};
          div_d    = bus.divider;
          if (bus.enable) begin
            state_d   = ST_LOW;
            stopped_d = 1'b0;
          end else begin
            state_d   = ST_IDLE;
            stopped_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = {DIV_W{1'b0}};
        sd_clk_d  = 1'b0;
        stopped_d = 1'b1;
      end
    endcase
  end

  assign bus.sd_clk  = sd_clk_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.stopped = stopped_q;

endmodule
